// File: rtl/ra_bist_chk_sdr_if.sv
// ra_bist_chk_sdr_if: control, read-port taps and status of the SDR 2R1W 64x72 read-response checker.
interface ra_bist_chk_sdr_if;
   logic [31:0] ctl;
   logic        rd0_enb;
   logic [5:0]  rd0_adr;
   logic [71:0] rd0_dat;
   logic        rd1_enb;
   logic [5:0]  rd1_adr;
   logic [71:0] rd1_dat;
   logic [31:0] status;
   logic        fail;
   modport master (output ctl, rd0_enb, rd0_adr, rd0_dat, rd1_enb, rd1_adr, rd1_dat, input status, fail);
   modport slave (input ctl, rd0_enb, rd0_adr, rd0_dat, rd1_enb, rd1_adr, rd1_dat, output status, fail);
endinterface

// File: rtl/ra_bist_chk_sdr.sv
// ra_bist_chk_sdr: tracks reads on both array ports for RD_LAT cycles and checks returned data
// against the pattern captured at issue, keeping a saturating fail count and first-fail record.
module ra_bist_chk_sdr #(
   parameter int RD_LAT = 1
) (
   input logic clk,
   input logic reset,
   ra_bist_chk_sdr_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   // stages that will still hold an entry after the next edge (all but the exiting one)
   localparam logic [RD_LAT-1:0] live = RD_LAT'((64'd1 << (RD_LAT - 1)) - 64'd1);
   state_t state, state_nxt;
   logic [RD_LAT-1:0] vld0, vld1;
   logic [8:0] trk0 [RD_LAT];
   logic [8:0] trk1 [RD_LAT];
   logic [71:0] d0, d1;
   logic [16:0] sum;
   logic [15:0] cnt;
   logic [5:0] ff_adr;
   logic [6:0] ff_bit;
   logic ff_port, fail_q, clr, iss0, iss1, m0, m1, pend, unused_ctl;
   function automatic logic [71:0] exp_word(input logic [8:0] t);
      logic [71:0] e;
      e = t[7:6] == 2'd0 ? '0 : t[7:6] == 2'd1 ? '1 :
          t[7:6] == 2'd2 ? (t[0] ? {36{2'b01}} : {36{2'b10}}) : {12{t[5:0]}};
      return e ^ {72{t[8]}};
   endfunction
   function automatic logic [6:0] low_bit(input logic [71:0] d);
      logic [6:0] b;
      b = '0;
      for (int i = 71; i >= 0; i--) if (d[i]) b = 7'(i);
      return b;
   endfunction
   assign unused_ctl = ^bus.ctl[31:7];
   assign clr = reset | bus.ctl[1];
   assign iss0 = bus.rd0_enb & bus.ctl[0] & ~bus.ctl[1] & ~bus.ctl[5];
   assign iss1 = bus.rd1_enb & bus.ctl[0] & ~bus.ctl[1] & ~bus.ctl[6];
   assign d0 = exp_word(trk0[RD_LAT-1]) ^ bus.rd0_dat;
   assign d1 = exp_word(trk1[RD_LAT-1]) ^ bus.rd1_dat;
   assign m0 = vld0[RD_LAT-1] & |d0;
   assign m1 = vld1[RD_LAT-1] & |d1;
   assign pend = |((vld0 | vld1) & live);
   assign sum = {1'b0, cnt} + 17'(m0) + 17'(m1);
   assign bus.status = {state != IDLE, fail_q, ff_port, ff_adr, ff_bit, cnt};
   assign bus.fail = fail_q;
   always_comb begin
      state_nxt = state;
      state_nxt = bus.ctl[0] ? RUN : (state != IDLE && pend) ? DRAIN : IDLE;
   end
   always_ff @(posedge clk) begin
      state <= clr ? IDLE : state_nxt;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         vld0 <= '0;
         vld1 <= '0;
      end else begin
         vld0[0] <= iss0;
         vld1[0] <= iss1;
         for (int i = 1; i < RD_LAT; i++) begin
            vld0[i] <= vld0[i-1];
            vld1[i] <= vld1[i-1];
         end
      end
   end
   // settings ride with the request so later ctl changes leave in-flight compares alone
   always_ff @(posedge clk) begin
      trk0[0] <= {bus.ctl[4:2], bus.rd0_adr};
      trk1[0] <= {bus.ctl[4:2], bus.rd1_adr};
      for (int i = 1; i < RD_LAT; i++) begin
         trk0[i] <= trk0[i-1];
         trk1[i] <= trk1[i-1];
      end
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
         fail_q <= 1'b0;
         ff_port <= 1'b0;
         ff_adr <= '0;
         ff_bit <= '0;
      end else begin
         cnt <= sum[16] ? 16'hFFFF : sum[15:0];
         if (!fail_q && (m0 || m1)) begin
            fail_q <= 1'b1;
            ff_port <= ~m0;
            ff_adr <= m0 ? trk0[RD_LAT-1][5:0] : trk1[RD_LAT-1][5:0];
            ff_bit <= low_bit(m0 ? d0 : d1);
         end
      end
   end
endmodule
